// File: rtl/r_format_pkg.sv
// -----------------------------------------------------------------------------
// r_format_pkg
// Shared constants for the R-format register read stage: instruction field
// bit positions, funct codes, ALU opcodes, the register address width and a
// decode helper that maps (op, funct) to an ALU opcode plus an illegal flag.
// -----------------------------------------------------------------------------
package r_format_pkg;

  // Register address width (log2 of the 32-entry register file).
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned INSTR_W = 32;

  // Instruction field bit positions.
  localparam int unsigned OP_MSB    = 31;
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_MSB    = 25;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_MSB    = 20;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_MSB    = 15;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_MSB = 10;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_MSB = 5;
  localparam int unsigned FUNCT_LSB = 0;

  // Supported funct codes (op must be zero).
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [5:0] OP_RTYPE  = 6'h00;

  // ALU opcodes presented downstream.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       illegal;
  } decode_t;

  // Unsupported encodings still produce a bundle; they fall back to ADD and
  // raise the illegal flag so the write-back stage can drop the result.
  function automatic decode_t decode_r(input logic [5:0] op, input logic [5:0] funct);
    decode_t res;
    res.alu_op  = ALU_ADD;
    res.illegal = 1'b1;
    if (op == OP_RTYPE) begin
      case (funct)
        FUNCT_ADD: begin res.alu_op = ALU_ADD; res.illegal = 1'b0; end
        FUNCT_SUB: begin res.alu_op = ALU_SUB; res.illegal = 1'b0; end
        FUNCT_AND: begin res.alu_op = ALU_AND; res.illegal = 1'b0; end
        FUNCT_OR:  begin res.alu_op = ALU_OR;  res.illegal = 1'b0; end
        FUNCT_SLT: begin res.alu_op = ALU_SLT; res.illegal = 1'b0; end
        default:   begin res.alu_op = ALU_ADD; res.illegal = 1'b1; end
      endcase
    end else begin
      res.alu_op  = ALU_ADD;
      res.illegal = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// NREGS x DATA_W register file with two asynchronous read ports and one
// synchronous write port. Register 0 reads as zero and ignores writes.
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined   - a read whose address matches an in-flight write (same cycle,
//               non-zero address) returns the write data.
//   undefined - such a read returns the value stored before the write.
//
// Ports:
//   clk        - clock, write on rising edge
//   rst_n      - asynchronous active-low reset, clears all storage
//   we_i       - write enable
//   waddr_i    - write address
//   wdata_i    - write data
//   raddr_a_i  - read port A address   rdata_a_o - read port A data
//   raddr_b_i  - read port B address   rdata_b_o - read port B data
// -----------------------------------------------------------------------------
module regfile_2r1w
  import r_format_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] rdata_a_s;
  logic [DATA_W-1:0] rdata_b_s;

  // Storage write port; address 0 is never written so it stays at its reset zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port A with zero-register forcing and optional write bypass.
  always_comb begin
    rdata_a_s = '0;
    if (raddr_a_i == '0) begin
      rdata_a_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (we_i && (waddr_i == raddr_a_i)) begin
      rdata_a_s = wdata_i;
`endif
    end else begin
      rdata_a_s = mem_q[raddr_a_i];
    end
  end

  // Read port B with zero-register forcing and optional write bypass.
  always_comb begin
    rdata_b_s = '0;
    if (raddr_b_i == '0) begin
      rdata_b_s = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (we_i && (waddr_i == raddr_b_i)) begin
      rdata_b_s = wdata_i;
`endif
    end else begin
      rdata_b_s = mem_q[raddr_b_i];
    end
  end

  assign rdata_a_o = rdata_a_s;
  assign rdata_b_o = rdata_b_s;

endmodule

// File: rtl/register_read_stage.sv
// -----------------------------------------------------------------------------
// register_read_stage
// Decode and operand fetch for R-format instructions. An accepted instruction
// is split into fields, its rs/rt operands are read from the internal register
// file, and the bundle is presented from a single output register one cycle
// later. The register file's write port is driven by the write-back stage.
//
// Configuration macro: REGFILE_BYPASS_EN (see regfile_2r1w) selects whether a
// same-cycle write-back is forwarded into the operands being fetched.
//
// Ports:
//   clk, reset_input (async active-low)
//   in_valid / in_ready / instr           - instruction handshake
//   out_valid / out_ready                 - output bundle handshake
//   ALU_operation, illegal                - decode result
//   rs_address, rt_address, out_address   - rs, rt, rd fields
//   rs_data, rt_data                      - operand values sampled at accept
//   wb_enable, wb_address, wb_data        - register file write port
// -----------------------------------------------------------------------------
module register_read_stage
  import r_format_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic               clk,
  input  logic               reset_input,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         ALU_operation,
  output logic [ADDR_W-1:0]  rs_address,
  output logic [ADDR_W-1:0]  rt_address,
  output logic [ADDR_W-1:0]  out_address,
  output logic [DATA_W-1:0]  rs_data,
  output logic [DATA_W-1:0]  rt_data,
  output logic               illegal,
  input  logic               wb_enable,
  input  logic [ADDR_W-1:0]  wb_address,
  input  logic [DATA_W-1:0]  wb_data
);

  // Field extraction.
  logic [5:0]        op_s;
  logic [5:0]        funct_s;
  logic [ADDR_W-1:0] rs_s;
  logic [ADDR_W-1:0] rt_s;
  logic [ADDR_W-1:0] rd_s;
  logic [4:0]        unused_shamt_s;

  assign op_s           = instr[OP_MSB:OP_LSB];
  assign rs_s           = instr[RS_MSB:RS_LSB];
  assign rt_s           = instr[RT_MSB:RT_LSB];
  assign rd_s           = instr[RD_MSB:RD_LSB];
  assign unused_shamt_s = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct_s        = instr[FUNCT_MSB:FUNCT_LSB];

  logic [DATA_W-1:0] rs_rdata_s;
  logic [DATA_W-1:0] rt_rdata_s;
  decode_t           dec_s;
  logic              accept_s;

  // Output register state and its next-state values.
  logic              out_valid_q, out_valid_d;
  logic [2:0]        alu_op_q,    alu_op_d;
  logic              illegal_q,   illegal_d;
  logic [ADDR_W-1:0] rs_addr_q,   rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q,   rt_addr_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic [DATA_W-1:0] rs_data_q,   rs_data_d;
  logic [DATA_W-1:0] rt_data_q,   rt_data_d;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (reset_input),
    .we_i      (wb_enable),
    .waddr_i   (wb_address),
    .wdata_i   (wb_data),
    .raddr_a_i (rs_s),
    .raddr_b_i (rt_s),
    .rdata_a_o (rs_rdata_s),
    .rdata_b_o (rt_rdata_s)
  );

  assign dec_s = decode_r(op_s, funct_s);

  // Single output register: room exists when empty or being drained this cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept_s = in_valid && in_ready;

  // Next-state for the output bundle: capture on accept, clear valid on a bare pop.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    illegal_d   = illegal_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rd_addr_d   = rd_addr_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      alu_op_d    = dec_s.alu_op;
      illegal_d   = dec_s.illegal;
      rs_addr_d   = rs_s;
      rt_addr_d   = rt_s;
      rd_addr_d   = rd_s;
      rs_data_d   = rs_rdata_s;
      rt_data_d   = rt_rdata_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output bundle register.
  always_ff @(posedge clk or negedge reset_input) begin
    if (!reset_input) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= 3'b000;
      illegal_q   <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      illegal_q   <= illegal_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign ALU_operation = alu_op_q;
  assign illegal       = illegal_q;
  assign rs_address    = rs_addr_q;
  assign rt_address    = rt_addr_q;
  assign out_address   = rd_addr_q;
  assign rs_data       = rs_data_q;
  assign rt_data       = rt_data_q;

endmodule

// File: doc/register_read_stage.md
# register_read_stage

Decode-and-operand-fetch stage for R-format instructions, feeding the ALU/register-write stage. Accepts a 32-bit instruction word over a valid/ready handshake and splits it into fields. It reads `rs`/`rt` from an internal 32×32 register file and presents ALU operation, operand data and destination address one cycle later. It also owns the register file's single write port, which the register-write stage drives with its result.

## Interface
Parameters:
- `DATA_W`, 32: register and operand width.
- `NREGS`, 32: register count. Address width is log2(NREGS) = 5.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_input`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: `instr` is valid.
- `in_ready`, out, 1: the stage can accept `instr` this cycle.
- `instr`, in, 32: R-format word: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- `out_valid`, out, 1: the output bundle is valid.
- `out_ready`, in, 1: downstream accepts the bundle.
- `ALU_operation`, out, 3: ALU opcode.
- `rs_address`, `rt_address`, `out_address`, out, 5 each: rs, rt and rd fields.
- `rs_data`, `rt_data`, out, DATA_W each: operand values.
- `illegal`, out, 1: op≠0 or funct is unsupported.
- `wb_enable`, in, 1: write-back strobe.
- `wb_address`, in, 5: write-back destination.
- `wb_data`, in, DATA_W: write-back value.

## Operation
- Handshake:
  - Accept occurs when `in_valid && in_ready`.
  - `in_ready = !out_valid || out_ready`, giving a single output register with no skid buffer.
  - On accept, all output fields are captured and `out_valid` is set to 1.
  - If `out_valid && out_ready` and there is no accept in the same cycle, `out_valid` clears to 0.
  - While `out_valid && !out_ready`, every output holds stable.
- Decode from funct (op must be 0):
  - 0x20 ADD → 3'b010.
  - 0x22 SUB → 3'b110.
  - 0x24 AND → 3'b000.
  - 0x25 OR → 3'b001.
  - 0x2A SLT → 3'b111.
  - Any other funct, or op≠0: `illegal`=1 and `ALU_operation`=3'b010. The bundle is still delivered; downstream must not write it back.
- Register file:
  - Write: 32×DATA_W. On a rising edge with `wb_enable`=1, write `wb_data` to `wb_address`. The write is independent of the handshake.
  - Register 0 is hardwired zero: writes to it are discarded and reads of it return 0.
  - Read: operands are sampled at accept only. A held bundle does not track later writes, so stale data in a stalled bundle is permitted.
- Reset (`reset_input`=0), asynchronous and immediate:
  - All registers are cleared to 0.
  - `out_valid`=0, all data and address outputs are 0, `ALU_operation`=0, `illegal`=0.
  - Reset asserted mid-stall discards the bundle.

## Timing
- Latency: 1 cycle from accept to `out_valid`. Throughput is 1 instruction per cycle while `out_ready`=1.
- `in_ready` is combinational from `out_valid` and `out_ready`.
- Simultaneous accept and pop: the new bundle replaces the old one with no bubble.
- Write and accept in the same cycle where `wb_address` equals rs or rt (and is non-zero): this is a read-during-write collision. The result depends on the Configuration option.
- A write-back is visible to any accept on a later cycle.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - On a same-cycle collision, the operand takes `wb_data`, i.e. the new value.
  - This applies independently to rs and rt. Address 0 is never bypassed.
- `REGFILE_BYPASS_EN` undefined:
  - On a collision, the operand takes the pre-write register value.
  - The bench expects the old value.

## Structure
- Package `r_format_pkg`:
  - funct codes and ALU opcode localparams.
  - Instruction field bit positions.
  - Address width constant.
- Sub-module `regfile_2r1w`:
  - Storage plus asynchronous read ports and a synchronous write port.
  - Zero-register handling.
  - The bypass mux, under the macro.
- The top level holds the decode logic, the output register and the handshake.

## Test plan
- Write-back then read:
  - Stimulus: wb r9=0x0000_0005 and r10=0x0000_0007, then accept ADD rd=13, rs=9, rt=10 (0x012A6820).
  - Required: next cycle `out_valid`=1, `rs_data`=5, `rt_data`=7, `out_address`=13, `ALU_operation`=3'b010.
- Zero register:
  - Stimulus: wb r0=0xFFFF_FFFF, then read with rs=0.
  - Required: `rs_data`=0.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles with `in_valid`=1.
  - Required: `in_ready`=0, the bundle is held bit-stable, a single accept occurs, and the next instruction appears on the cycle after `out_ready` rises.
- Collision:
  - Stimulus: in the same cycle, wb r9=0x11 (previously 5) and accept an instruction with rs=9.
  - Required: `rs_data`=0x11 with the macro, 5 without it.
- Illegal:
  - Stimulus: funct 0x08, or op=0x23.
  - Required: `illegal`=1 and `ALU_operation`=3'b010.
- Reset mid-stall:
  - Stimulus: assert `reset_input`=0 while `out_valid`=1 and `out_ready`=0.
  - Required: `out_valid`=0 immediately; after release, every register reads 0.
